// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// spi_xfer_arbiter : round-robin arbiter sharing one SPI byte engine between
//                    a CPU path and a sensor poller, with CS hold and timeout.
// Revision: 1.0
// ============================================================================
module spi_xfer_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic [1:0] err,
  output logic [7:0] rx_data,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       cs_n
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        cs_n_q, cs_n_d;
  logic [15:0] timer_q, timer_d;

  logic        tmo;
  logic        pick;
  logic        rel;
  logic        abort;
  logic [1:0]  owner_oh;

  assign owner_oh = owner_q ? 2'b10 : 2'b01;
  // >= so a START that launches a byte on the last cycle still aborts in WAIT
  assign tmo      = (timer_q >= TMO_LAST);
  assign pick     = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    rx_d    = rx_q;
    tx_d    = tx_q;
    cs_n_d  = cs_n_q;
    timer_d = timer_q + 16'd1;
    rel     = 1'b0;
    abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = timer_q;
        if (req != 2'b00) begin
          owner_d = pick;
          tx_d    = pick ? tx_data1 : tx_data0;
          gnt_d   = pick ? 2'b10 : 2'b01;
          cs_n_d  = 1'b0;
          timer_d = 16'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!spi_busy) begin
          state_d = ST_WAIT;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      ST_WAIT: begin
        if (spi_done) begin
          rx_d  = spi_rx;
          ack_d = owner_oh;
          if (lock[owner_q]) begin
            state_d = ST_HOLD;
            timer_d = 16'd0;
          end else begin
            rel = 1'b1;
          end
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      ST_HOLD: begin
        if (req[owner_q]) begin
          tx_d    = owner_q ? tx_data1 : tx_data0;
          timer_d = 16'd0;
          state_d = ST_START;
        end else if (!lock[owner_q]) begin
          rel = 1'b1;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rel || abort) begin
      state_d = ST_IDLE;
      gnt_d   = 2'b00;
      cs_n_d  = 1'b1;
      last_d  = owner_q;
      timer_d = timer_q;
    end
    if (abort) begin
      err_d = owner_oh;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rx_q    <= 8'h00;
      tx_q    <= 8'h00;
      cs_n_q  <= 1'b1;
      timer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      cs_n_q  <= cs_n_d;
      timer_q <= timer_d;
    end
  end

  assign spi_start = (state_q == ST_START) && !spi_busy && !HRESET;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rx_data   = rx_q;
  assign spi_tx    = tx_q;
  assign cs_n      = cs_n_q;

endmodule
`default_nettype wire
